// File: rtl/sevenseg_pkg.sv
// Shared constants, FSM state type and helpers for the seven-segment display driver.
package sevenseg_pkg;

   // Active-low segment patterns, bit order g..a
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b011_1111;

   // Binary-to-BCD converter states
   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } conv_state_t;

   // Largest unsigned value that fits in n decimal digits: 10^n - 1
   function automatic logic [31:0] max_dec(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int k = 0; k < n; k++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage

// File: rtl/sevenseg_digit.sv
// Combinational nibble to active-low seven-segment decoder (g..a).
module sevenseg_digit
   import sevenseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Hex glyph lookup; upper-case A, C, E, F and lower-case b, d
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = 7'b100_0000;
         4'h1: seg = 7'b111_1001;
         4'h2: seg = 7'b010_0100;
         4'h3: seg = 7'b011_0000;
         4'h4: seg = 7'b001_1001;
         4'h5: seg = 7'b001_0010;
         4'h6: seg = 7'b000_0010;
         4'h7: seg = 7'b111_1000;
         4'h8: seg = 7'b000_0000;
         4'h9: seg = 7'b001_0000;
         4'hA: seg = 7'b000_1000;
         4'hB: seg = 7'b000_0011;
         4'hC: seg = 7'b100_0110;
         4'hD: seg = 7'b010_0001;
         4'hE: seg = 7'b000_0110;
         4'hF: seg = 7'b000_1110;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sevenseg_display.sv
// Multi-digit seven-segment driver: latches a written value and shows it as hex
// or as unsigned decimal (sequential shift-add-3 conversion), with leading-zero
// blanking, overflow dashes and whole-display blinking.
module sevenseg_display
   import sevenseg_pkg::*;
#(
   parameter int NDIGITS   = 6,
   parameter int BLINK_DIV = 25_000_000
)
(
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   wr_en,
   input  logic [4*NDIGITS-1:0]   wr_data,
   input  logic                   dec_mode,
   input  logic                   blank_lz,
   input  logic                   blink_en,
   output logic                   busy,
   output logic [7*NDIGITS-1:0]   hex_out
);

   localparam int W     = 4 * NDIGITS;
   localparam int CNT_W = $clog2(W);
   localparam int BLK_W = $clog2(BLINK_DIV);

   localparam logic [32:0]      MAX_VAL  = {1'b0, max_dec(NDIGITS)};
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
   localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_DIV - 1);

   conv_state_t        state, state_next;
   logic [W-1:0]       disp, disp_next;
   logic               ovf, ovf_next;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
   // Combined {bcd, binary} shift register; bcd in the upper half
   logic [2*W-1:0]     shift, shift_next;
   logic [2*W-1:0]     shift_adj;
   logic [2*W-1:0]     shift_rot;
   logic [W-1:0]       bcd_adj;
   logic               wr_too_big;

   logic [BLK_W-1:0]   blink_cnt;
   logic               phase;
   logic               blink_off;
   logic [NDIGITS-1:0] lz_blank;

   assign wr_too_big = (33'(wr_data) > MAX_VAL);
   assign busy       = (state == CONV);

   // Add-3 correction of every BCD nibble that is 5 or more
   generate
      for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_adj
         logic [3:0] nib;
         assign nib = shift[W + 4*gi +: 4];
         assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      end
   endgenerate

   // The shift is done as a rotate of the whole register: the bit leaving the
   // top BCD digit lands in the spent low binary bit, where it is never read.
   assign shift_adj = {bcd_adj, shift[W-1:0]};
   assign shift_rot = {shift_adj[2*W-2:0], shift_adj[2*W-1]};

   // Converter state and display/overflow registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         disp    <= '0;
         ovf     <= 1'b0;
         bit_cnt <= '0;
         shift   <= '0;
      end else begin
         state   <= state_next;
         disp    <= disp_next;
         ovf     <= ovf_next;
         bit_cnt <= bit_cnt_next;
         shift   <= shift_next;
      end
   end

   // Next-state: accept writes in IDLE, run exactly W shift-add-3 steps in CONV
   always_comb begin
      state_next   = state;
      disp_next    = disp;
      ovf_next     = ovf;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      case (state)
         IDLE: begin
            if (wr_en) begin
               if (!dec_mode) begin
                  disp_next = wr_data;
                  ovf_next  = 1'b0;
               end else if (wr_too_big) begin
                  ovf_next  = 1'b1;
               end else begin
                  state_next   = CONV;
                  bit_cnt_next = '0;
                  shift_next   = {{W{1'b0}}, wr_data};
               end
            end
         end
         CONV: begin
            shift_next   = shift_rot;
            bit_cnt_next = bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
               disp_next  = shift_rot[2*W-1:W];
               ovf_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Blink timebase: counter and phase held at zero while blinking is disabled
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (!blink_en) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == LAST_BLK) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BLK_W'(1);
      end
   end

   assign blink_off = blink_en & phase;

   // Leading-zero mask: blank zero digits from the top until the first nonzero
   always_comb begin
      logic lead;
      lz_blank = '0;
      lead     = blank_lz & ~ovf;
      for (int i = NDIGITS - 1; i >= 1; i--) begin
         if (disp[4*i +: 4] != 4'd0) begin
            lead = 1'b0;
         end
         lz_blank[i] = lead;
      end
   end

   // Per-digit decode and output priority: blink > dash > blank > glyph
   generate
      for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
         logic [6:0] seg;
         sevenseg_digit u_digit (
            .nibble (disp[4*gi +: 4]),
            .seg    (seg)
         );
         assign hex_out[7*gi +: 7] = blink_off    ? SEG_BLANK :
                                     ovf          ? SEG_DASH  :
                                     lz_blank[gi] ? SEG_BLANK : seg;
      end
   endgenerate

endmodule

// File: tb/tb_sevenseg_display.sv
// Scoreboard bench for sevenseg_display with 4 digits and a 4-cycle blink half-period.
module tb_sevenseg_display;

   localparam int ND = 4;
   localparam int W  = 4 * ND;
   localparam int BD = 4;
   localparam logic [7*ND-1:0] ALL_DASH  = {ND{7'b011_1111}};
   localparam logic [7*ND-1:0] ALL_BLANK = {ND{7'b111_1111}};

   logic            clock = 1'b0;
   logic            resetn;
   logic            wr_en;
   logic [W-1:0]    wr_data;
   logic            dec_mode;
   logic            blank_lz;
   logic            blink_en;
   logic            busy;
   logic [7*ND-1:0] hex_out;

   int n_cmp = 0;
   int n_err = 0;
   logic [7*ND-1:0] exp_q [$];
   logic [7*ND-1:0] exp_v;

   sevenseg_display #(.NDIGITS(ND), .BLINK_DIV(BD)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .dec_mode (dec_mode),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .busy     (busy),
      .hex_out  (hex_out)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'b100_0000;  4'h1: return 7'b111_1001;
         4'h2: return 7'b010_0100;  4'h3: return 7'b011_0000;
         4'h4: return 7'b001_1001;  4'h5: return 7'b001_0010;
         4'h6: return 7'b000_0010;  4'h7: return 7'b111_1000;
         4'h8: return 7'b000_0000;  4'h9: return 7'b001_0000;
         4'hA: return 7'b000_1000;  4'hB: return 7'b000_0011;
         4'hC: return 7'b100_0110;  4'hD: return 7'b010_0001;
         4'hE: return 7'b000_0110;  default: return 7'b000_1110;
      endcase
   endfunction

   function automatic logic [7*ND-1:0] render(input logic [W-1:0] val, input logic blz);
      logic [7*ND-1:0] r;
      logic [3:0]      nb;
      bit              lead;
      lead = 1'b1;
      r    = '0;
      for (int i = ND - 1; i >= 0; i--) begin
         nb = val[4*i +: 4];
         if (lead && blz && i != 0 && nb == 4'd0) begin
            r[7*i +: 7] = 7'h7F;
         end else begin
            lead = 1'b0;
            r[7*i +: 7] = seg_of(nb);
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] b;
      int           t;
      b = '0;
      t = v;
      for (int i = 0; i < ND; i++) begin
         b[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return b;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Counts samples with busy high after the accepting edge, bounded at 60
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 60) begin
         tick();
         cycles++;
      end
   endtask

   task automatic write(input logic [W-1:0] d, input logic dm);
      wr_data  = d;
      dec_mode = dm;
      wr_en    = 1'b1;
      tick();
      wr_en    = 1'b0;
   endtask

   task automatic pop_check(input string name);
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty, hex_out=%h", name, hex_out);
      end else begin
         exp_v = exp_q.pop_front();
         if (hex_out !== exp_v) begin
            n_err++;
            $display("FAIL %s: hex_out=%h expected=%h", name, hex_out, exp_v);
         end else begin
            $display("ok   %s: hex_out=%h", name, hex_out);
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; wr_en = 1'b0; wr_data = '0; dec_mode = 1'b0;
      blank_lz = 1'b1; blink_en = 1'b0;
      tick(); tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy: busy=%b expected=0", busy);
      end
      exp_q.push_back(render('0, 1'b1));
      pop_check("reset_blz1");
      blank_lz = 1'b0; #1;
      exp_q.push_back(render('0, 1'b0));
      pop_check("reset_blz0");
      blank_lz = 1'b1;
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_hex();
      logic [W-1:0] vals [4];
      vals[0] = 16'h00A5; vals[1] = 16'hBEEF; vals[2] = 16'h0F00; vals[3] = 16'h00A5;
      for (int i = 0; i < 4; i++) begin
         blank_lz = (i != 1);
         exp_q.push_back(render(vals[i], blank_lz));
         write(vals[i], 1'b0);
         pop_check($sformatf("hex_%h", vals[i]));
         n_cmp++;
         if (busy !== 1'b0) begin
            n_err++; $display("FAIL hex_busy: busy=%b expected=0", busy);
         end
      end
   endtask

   task automatic test_decimal(input int v, input logic [7*ND-1:0] held);
      int cyc;
      int hold_bad;
      hold_bad = 0;
      exp_q.push_back(render(to_bcd(v), blank_lz));
      write(W'(v), 1'b1);
      cyc = 0;
      while (busy === 1'b1 && cyc < 60) begin
         if (hex_out !== held) hold_bad++;
         tick();
         cyc++;
      end
      n_cmp++;
      if (cyc != W) begin
         n_err++; $display("FAIL dec_%0d_busy_len: busy cycles=%0d expected=%0d", v, cyc, W);
      end
      n_cmp++;
      if (hold_bad != 0) begin
         n_err++; $display("FAIL dec_%0d_hold: %0d samples changed, expected held %h", v, hold_bad, held);
      end
      pop_check($sformatf("dec_%0d", v));
   endtask

   task automatic test_overflow();
      int busy_seen;
      busy_seen = 0;
      exp_q.push_back(ALL_DASH);
      write(16'd10000, 1'b1);
      pop_check("ovf_dash");
      for (int i = 0; i < 5; i++) begin
         if (busy !== 1'b0) busy_seen++;
         tick();
      end
      n_cmp++;
      if (busy_seen != 0) begin
         n_err++; $display("FAIL ovf_busy: busy seen %0d times expected 0", busy_seen);
      end
      blank_lz = 1'b1;
      exp_q.push_back(render(16'h0000, 1'b1));
      write(16'h0000, 1'b0);
      pop_check("ovf_clear_hex0");
   endtask

   task automatic test_back_to_back();
      int cyc;
      exp_q.push_back(render(16'h0042, 1'b0));
      write(16'd42, 1'b1);
      tick(); tick();
      write(16'h9999, 1'b0);
      blank_lz = 1'b0;
      wait_idle(cyc);
      n_cmp++;
      if (cyc != W - 3) begin
         n_err++; $display("FAIL b2b_busy_len: remaining busy=%0d expected=%0d", cyc, W - 3);
      end
      pop_check("b2b_result");
      tick(); tick(); tick();
      exp_q.push_back(render(16'h0042, 1'b0));
      pop_check("b2b_no_queue");
   endtask

   task automatic test_blink();
      blank_lz = 1'b1;
      exp_q.push_back(render(16'h0007, 1'b1));
      write(16'h0007, 1'b0);
      pop_check("blink_setup");
      blink_en = 1'b1;
      for (int k = 0; k < 14; k++) begin
         exp_q.push_back(((k / BD) % 2 == 0) ? render(16'h0007, 1'b1) : ALL_BLANK);
         #1;
         pop_check($sformatf("blink_k%0d", k));
         tick();
      end
      blink_en = 1'b0;
      #1;
      exp_q.push_back(render(16'h0007, 1'b1));
      pop_check("blink_off_now");
      tick();
      exp_q.push_back(render(16'h0007, 1'b1));
      pop_check("blink_off_next");
      blink_en = 1'b1;
      for (int k = 0; k < BD + 1; k++) begin
         exp_q.push_back((k < BD) ? render(16'h0007, 1'b1) : ALL_BLANK);
         #1;
         pop_check($sformatf("blink_restart_k%0d", k));
         tick();
      end
      blink_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_during_conv();
      int bad;
      bad = 0;
      blank_lz = 1'b1;
      write(16'd5678, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      resetn = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL rst_conv_busy: busy=%b expected=0", busy);
      end
      exp_q.push_back(render('0, 1'b1));
      pop_check("rst_conv_zero");
      tick(); tick();
      resetn = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (busy !== 1'b0 || hex_out !== render('0, 1'b1)) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++; $display("FAIL rst_conv_after: %0d bad samples, expected busy=0 hex_out=%h", bad, render('0, 1'b1));
      end
   endtask

   initial begin
      test_reset();
      test_hex();
      test_decimal(1234, render(16'h00A5, 1'b1));
      test_decimal(9999, render(to_bcd(1234), 1'b1));
      test_overflow();
      test_back_to_back();
      test_blink();
      test_reset_during_conv();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sevenseg_display.md
Name: sevenseg_display

Overview:
- Parametrised multi-digit seven-segment display driver for the memory-mapped I/O output port.
- Latches a written value and renders it on NDIGITS active-low segment fields, as hexadecimal or as unsigned decimal.
- Decimal values go through a sequential binary-to-BCD converter (shift-add-3).
- Adds leading-zero blanking, overflow indication and a blink mode.

Parameters:
- NDIGITS, 6: number of digits; legal range 1..8; W = 4*NDIGITS is the data width.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; must be >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe, one-cycle pulse, sampled on the rising edge.
- wr_data  in  W  value to display.
- dec_mode  in  1  sampled with wr_en; 1 = treat wr_data as unsigned binary and show decimal, 0 = show hex nibbles.
- blank_lz  in  1  live; 1 = blank leading zero digits.
- blink_en  in  1  live; 1 = blink the whole display.
- busy  out  1  high while a decimal conversion is in progress.
- hex_out  out  7*NDIGITS  digit i occupies bits [7i+6:7i]; digit 0 is least significant; bit order g..a; active-low.

Behaviour:
- Segment encoding, active-low, g..a:
  - 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000
  - 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110
  - blank=111_1111, dash=011_1111.
- State: disp_reg (W bits), ovf flag, FSM {IDLE, CONV}, bit counter, shift register, blink counter, blink phase.
- Reset (asynchronous, any state):
  - disp_reg=0, ovf=0, FSM=IDLE, busy=0, blink counter=0, phase=0.
  - hex_out shows value 0: digit 0 = 100_0000; higher digits are 100_0000, or blank if blank_lz=1.
- Reset during CONV aborts the conversion; no partial result is ever displayed.
- Hex mode (IDLE, wr_en=1, dec_mode=0): disp_reg <= wr_data, ovf <= 0 at the same edge. hex_out reflects the new value combinationally after that edge (1-cycle latency).
- Decimal mode (IDLE, wr_en=1, dec_mode=1):
  - If wr_data > 10^NDIGITS-1: ovf <= 1 at that edge; no conversion; busy stays 0; all digits show dash.
  - Otherwise: FSM enters CONV and busy goes high from the next cycle.
  - Each CONV cycle: every BCD nibble >= 5 gets +3, then shift left one bit with the next binary MSB in.
  - Exactly W CONV cycles. On the final one, disp_reg <= BCD result, ovf <= 0, FSM returns to IDLE, busy drops at that same edge.
  - Old display is held throughout the conversion.
- wr_en while busy=1 is ignored: no queueing, no effect on the conversion in progress.
- Leading-zero blanking (blank_lz=1, ovf=0): scanning from digit NDIGITS-1 downward, each zero nibble is blanked until the first nonzero nibble. Digit 0 is never blanked. Applies in both modes.
- Blink counter:
  - Free-running 0..BLINK_DIV-1; phase toggles on each wrap.
  - blink_en=0 holds counter=0 and phase=0.
  - blink_en=1, phase=1: every digit is blank, overriding dash and blanking.
  - Blinking therefore starts with BLINK_DIV visible cycles.
- Priority per digit: blink-off > ovf dash > leading-zero blank > nibble decode.
- disp_reg and ovf change only on accepted writes, conversion completion or reset.

Decomposition:
- sevenseg_pkg holds:
  - constants SEG_BLANK=7'h7F and SEG_DASH=7'b011_1111;
  - FSM state typedef {IDLE, CONV};
  - function max_dec(n) returning 10^n-1.
- One sub-module, sevenseg_digit: combinational 4-bit nibble to 7-bit active-low encoding, instantiated NDIGITS times via generate.
- Blink, blanking and FSM logic stay in sevenseg_display.

Test Plan (NDIGITS=4, BLINK_DIV=4):
- Hex write 16'h00A5, blank_lz=1 -> next cycle hex_out = {111_1111, 111_1111, 000_1000, 001_0010}; busy stays 0.
- Decimal write 16'd1234 -> busy high for exactly 16 cycles, prior digits held; then hex_out = {111_1001, 010_0100, 011_0000, 001_1001}.
- Decimal write 16'd10000 -> next cycle all four digits = 011_1111, busy never asserts. Then hex write 16'h0000, blank_lz=1 -> {blank, blank, blank, 100_0000}.
- Decimal write 16'd42, then wr_en with 16'h9999 three cycles later -> the second write is ignored; after completion, blank_lz=0 gives hex_out = {100_0000, 100_0000, 001_1001, 010_0100}.
- blink_en=1 with value 16'h0007 -> 4 cycles with digit 0 = 111_1000, then 4 cycles all 111_1111, repeating. Dropping blink_en -> visible the next cycle.
- resetn low 5 cycles into a decimal conversion -> busy=0 and value 0 displayed immediately; the conversion result never appears after release.
